ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/rv_pkg.sv | 69 ++++++
 rtl/ex_stage_if.sv | 37 +++
 rtl/mul_iter.sv | 60 ++++++
 rtl/ex_stage.sv | 97 +++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the execute stage: ALUOp codes, ALU operation enum,
// multiplier FSM states and the operand forwarding rule.
package rv_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [6:0] FUNCT7_MUL = 7'b0000001;
    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRA = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
    } alu_op_e;

    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] wdata;
    } exmem_t;

    function automatic alu_op_e alu_decode(logic [1:0] aluop, logic [2:0] f3, logic [6:0] f7);
        alu_op_e op;
        op = ALU_ADD;
        case (aluop)
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_RTYPE: begin
                case (f3)
                    F3_ADD: begin
                        if (f7 == FUNCT7_ALT)      op = ALU_SUB;
                        else if (f7 == FUNCT7_MUL) op = ALU_MUL;
                    end
                    F3_AND:  op = ALU_AND;
                    F3_OR:   op = ALU_OR;
                    F3_XOR:  op = ALU_XOR;
                    F3_SLL:  op = ALU_SLL;
                    default: op = ALU_ADD;
                endcase
            end
            ALUOP_ITYPE: if (f3 == F3_SRA && f7 == FUNCT7_ALT) op = ALU_SRA;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
    function automatic logic [31:0] fwd_select(logic [4:0] addr, logic [31:0] reg_val,
                                               logic mem_we, logic [4:0] mem_rd, logic [31:0] mem_val,
                                               logic wb_we, logic [4:0] wb_rd, logic [31:0] wb_val);
        if (mem_we && mem_rd != 5'd0 && mem_rd == addr) return mem_val;
        if (wb_we && wb_rd != 5'd0 && wb_rd == addr)    return wb_val;
        return reg_val;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage.
interface ex_stage_if;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] RS1data_i, RS2data_i, imm_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
    logic        MEM_RegWrite_i;
    logic [4:0]  MEM_RDaddr_i;
    logic [31:0] MEM_ALUResult_i;
    logic        WB_RegWrite_i;
    logic [4:0]  WB_RDaddr_i;
    logic [31:0] WB_WriteData_i;
    logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
    logic [31:0] ALUResult_o, MemWriteData_o;
    logic [4:0]  RDaddr_o;
    logic        stall_o;

    modport slave (
        input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
        input  RS1data_i, RS2data_i, imm_i, funct3_i, funct7_i, RS1addr_i, RS2addr_i, RDaddr_i,
        input  MEM_RegWrite_i, MEM_RDaddr_i, MEM_ALUResult_i,
        input  WB_RegWrite_i, WB_RDaddr_i, WB_WriteData_i,
        output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
        output ALUResult_o, MemWriteData_o, RDaddr_o, stall_o
    );

    modport master (
        output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
        output RS1data_i, RS2data_i, imm_i, funct3_i, funct7_i, RS1addr_i, RS2addr_i, RDaddr_i,
        output MEM_RegWrite_i, MEM_RDaddr_i, MEM_ALUResult_i,
        output WB_RegWrite_i, WB_RDaddr_i, WB_WriteData_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
        input  ALUResult_o, MemWriteData_o, RDaddr_o, stall_o
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low 32 bits kept.
//   state    | meaning
//   MUL_IDLE | waiting for start; operands captured on start
//   MUL_BUSY | accumulating bit cnt_q of the multiplier (32 cycles)
//   MUL_DONE | product valid for one cycle
module mul_iter
    import rv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);
    mul_state_e  state_q, state_d;
    logic [31:0] a_q, b_q, prod_q;
    logic [4:0]  cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= MUL_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start_i) state_d = MUL_BUSY;
            MUL_BUSY: if (cnt_q == 5'd31) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == MUL_BUSY);
        done_o = (state_q == MUL_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == MUL_IDLE && start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            prod_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == MUL_BUSY) begin
            if (b_q[cnt_q]) prod_q <= prod_q + (a_q << cnt_q);
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign product_o = prod_q;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL with
// pipeline stall, and the EX/MEM pipeline register.
module ex_stage
    import rv_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    ex_stage_if.slave bus_io
);
    logic [31:0] rs1_fwd, rs2_fwd, alu_b, alu_res, mul_product;
    alu_op_e     alu_op;
    logic        mul_start, mul_busy, mul_done;
    exmem_t      exmem_d, exmem_q, mul_ctrl_q;

    always_comb begin
        rs1_fwd = fwd_select(bus_io.RS1addr_i, bus_io.RS1data_i,
                             bus_io.MEM_RegWrite_i, bus_io.MEM_RDaddr_i, bus_io.MEM_ALUResult_i,
                             bus_io.WB_RegWrite_i, bus_io.WB_RDaddr_i, bus_io.WB_WriteData_i);
        rs2_fwd = fwd_select(bus_io.RS2addr_i, bus_io.RS2data_i,
                             bus_io.MEM_RegWrite_i, bus_io.MEM_RDaddr_i, bus_io.MEM_ALUResult_i,
                             bus_io.WB_RegWrite_i, bus_io.WB_RDaddr_i, bus_io.WB_WriteData_i);
        alu_b   = bus_io.ALUSrc_i ? bus_io.imm_i : rs2_fwd;
        alu_op  = alu_decode(bus_io.ALUOp_i, bus_io.funct3_i, bus_io.funct7_i);
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_res = rs1_fwd - alu_b;
            ALU_AND: alu_res = rs1_fwd & alu_b;
            ALU_OR:  alu_res = rs1_fwd | alu_b;
            ALU_XOR: alu_res = rs1_fwd ^ alu_b;
            ALU_SLL: alu_res = rs1_fwd << alu_b[4:0];
            ALU_SRA: alu_res = 32'($signed(rs1_fwd) >>> bus_io.imm_i[4:0]);
            default: alu_res = rs1_fwd + alu_b;
        endcase
    end

    // Gating with rst_i keeps stall low while reset is held with a MUL present.
    assign mul_start      = (alu_op == ALU_MUL) && !mul_busy && !mul_done && !rst_i;
    assign bus_io.stall_o = mul_start || mul_busy;

    mul_iter u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (rs1_fwd),
        .b_i       (alu_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mul_ctrl_q <= '0;
        end else if (mul_start) begin
            mul_ctrl_q.reg_write  <= bus_io.RegWrite_i;
            mul_ctrl_q.mem_to_reg <= bus_io.MemtoReg_i;
            mul_ctrl_q.mem_read   <= bus_io.MemRead_i;
            mul_ctrl_q.mem_write  <= bus_io.MemWrite_i;
            mul_ctrl_q.rd         <= bus_io.RDaddr_i;
            mul_ctrl_q.result     <= '0;
            mul_ctrl_q.wdata      <= rs2_fwd;
        end
    end

    always_comb begin
        exmem_d = '0;
        if (!bus_io.stall_o) begin
            if (mul_done) begin
                exmem_d        = mul_ctrl_q;
                exmem_d.result = mul_product;
            end else begin
                exmem_d.reg_write  = bus_io.RegWrite_i;
                exmem_d.mem_to_reg = bus_io.MemtoReg_i;
                exmem_d.mem_read   = bus_io.MemRead_i;
                exmem_d.mem_write  = bus_io.MemWrite_i;
                exmem_d.rd         = bus_io.RDaddr_i;
                exmem_d.result     = alu_res;
                exmem_d.wdata      = rs2_fwd;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) exmem_q <= '0;
        else       exmem_q <= exmem_d;
    end

    assign bus_io.RegWrite_o     = exmem_q.reg_write;
    assign bus_io.MemtoReg_o     = exmem_q.mem_to_reg;
    assign bus_io.MemRead_o      = exmem_q.mem_read;
    assign bus_io.MemWrite_o     = exmem_q.mem_write;
    assign bus_io.RDaddr_o       = exmem_q.rd;
    assign bus_io.ALUResult_o    = exmem_q.result;
    assign bus_io.MemWriteData_o = exmem_q.wdata;
endmodule
